// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 adder scheduler.
package fp16_pkg;

  localparam int unsigned FP16_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } sched_state_t;

  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid lane at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] pos;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IdxW'((32'(ptr) + k) % N);
      if (!found && valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/fp16_add_sched.sv
// Round-robin scheduler sharing one pipelined fp16 adder among N_REQ requesters,
// with a requester-ID tag pipe aligned to the adder latency and a drain handshake.
module fp16_add_sched import fp16_pkg::*; #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [16*N_REQ-1:0]           req_a,
  input  logic [16*N_REQ-1:0]           req_b,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [15:0]                   rsp_x,
  output logic [15:0]                   add_a,
  output logic [15:0]                   add_b,
  input  logic [15:0]                   add_x,
  input  logic                          drain_req,
  output logic                          drain_done,
  output logic [$clog2(ADD_LAT+3)-1:0]  inflight
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(ADD_LAT + 3);

  sched_state_t               state_q, state_d;
  logic [IdxW-1:0]            ptr_q, ptr_d, gidx;
  logic [N_REQ-1:0]           grant;
  logic                       xfer;
  logic [FP16_W-1:0]          add_a_q, add_a_d, add_b_q, add_b_d;
  logic [FP16_W-1:0]          rsp_x_q, rsp_x_d;
  logic [ADD_LAT:0]           tag_vld_q, tag_vld_d;
  logic [ADD_LAT:0][IdxW-1:0] tag_id_q, tag_id_d;
  logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [CntW-1:0]            inflight_q, inflight_d;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  // Grant depends only on registered state; masked while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && state_q == RUN) req_ready = grant;
    xfer = |req_ready;
  end

  always_comb begin
    add_a_d = FP16_ZERO;
    add_b_d = FP16_ZERO;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        add_a_d = req_a[i*FP16_W +: FP16_W];
        add_b_d = req_b[i*FP16_W +: FP16_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gidx == IdxW'(N_REQ - 1)) ? '0 : gidx + IdxW'(1);

    tag_vld_d = {tag_vld_q[ADD_LAT-1:0], xfer};
    tag_id_d  = {tag_id_q[ADD_LAT-1:0], gidx};

    rsp_x_d     = add_x;
    rsp_valid_d = '0;
    if (tag_vld_q[ADD_LAT]) rsp_valid_d[tag_id_q[ADD_LAT]] = 1'b1;

    // Decrement on the edge that raises rsp_valid, so drain sees zero in that cycle.
    inflight_d = inflight_q;
    case ({xfer, tag_vld_q[ADD_LAT]})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req)            state_d = RUN;
        else if (inflight_q == '0) state_d = HALT;
      end
      HALT:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      add_a_q     <= FP16_ZERO;
      add_b_q     <= FP16_ZERO;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_x_q     <= FP16_ZERO;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      inflight_q  <= inflight_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_x      = rsp_x_q;
  assign inflight   = inflight_q;
  assign drain_done = (state_q == HALT);

endmodule

// File: doc/fp16_add_sched.md
# fp16_add_sched

Round-robin scheduler sharing one pipelined `fp16adder` among `N_REQ` requesters (vertex-shader lanes). It accepts one add per cycle over a valid/ready handshake, drives the external adder's operand inputs, and tracks each operation's requester ID through a tag pipeline matched to the adder latency. Each result returns on a one-hot response strobe. A drain handshake lets the sequencer quiesce the adder before reconfiguration.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `ADD_LAT`, 2: cycles from `add_a`/`add_b` registered to `add_x` valid (≥1)
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req_valid` in N_REQ: per-requester operand valid
- `req_a` in 16*N_REQ: fp16 operand A, requester i at [16i+15:16i]
- `req_b` in 16*N_REQ: fp16 operand B, same packing
- `req_ready` out N_REQ: one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `rsp_valid` out N_REQ: one-hot result strobe, single cycle
- `rsp_x` out 16: fp16 sum for the strobed requester
- `add_a`, `add_b` out 16 each: operands to the adder
- `add_x` in 16: adder result
- `drain_req` in 1: level; stop accepting and empty the pipeline
- `drain_done` out 1: pipeline empty while draining
- `inflight` out clog2(ADD_LAT+3): operations accepted but not yet returned

## Operation
- States: RUN, DRAIN, HALT (encoding 0/1/2).
  - RUN→DRAIN when `drain_req`=1.
  - DRAIN→HALT when `inflight`=0.
  - HALT→RUN when `drain_req`=0.
  - DRAIN with `drain_req`=0 returns to RUN.
- Arbitration: only in RUN. Combinational grant picks the first `req_valid[i]` at or after pointer `ptr`, wrapping modulo N_REQ. At most one `req_ready` bit is high.
  - `ptr` ← granted index + 1 (mod N_REQ) only on a transfer. It wraps N_REQ-1 → 0.
  - `ptr` is unchanged when no request is valid.
- On a transfer, `add_a`/`add_b` are registered from the granted lane. With no transfer they are registered to 0.
- Tag pipe: ADD_LAT+1 stages of {valid, id}, shifted every cycle. Stage 0 is loaded with {transfer, granted id}.
- Output stage:
  - `rsp_x` is registered from `add_x`.
  - `rsp_valid` is the registered one-hot decode of the last tag stage.
- `inflight`: +1 on transfer, −1 on `rsp_valid` emission, unchanged when both happen in the same cycle. It never exceeds ADD_LAT+1.
- `drain_done` = (state==HALT).
- `req_ready` is a function of the registered state only. A transfer in the first cycle `drain_req` is seen still completes and is counted.
- Adder arithmetic (rounding, special values) is entirely owned by `fp16adder`. This block never alters operand or result bits.

## Timing
- Reset values:
  - `req_ready`=0 during reset.
  - `rsp_valid`=0, `rsp_x`=0, `add_a`=`add_b`=0.
  - `inflight`=0, `drain_done`=0, `ptr`=0, state=RUN, all tag stages invalid.
- Latency: transfer at edge E → `rsp_valid`/`rsp_x` valid in the cycle after edge E+ADD_LAT+1 (ADD_LAT+1 cycles).
- Throughput is one operation per cycle. There is no response backpressure; requesters must accept `rsp_valid` unconditionally.
- Results return in acceptance order.
- Reset asserted mid-operation discards all in-flight tags. No `rsp_valid` fires after reset deasserts for pre-reset operations.
- `drain_done` rises the cycle after the last `rsp_valid` of drained work.

## Structure
- Shared package `fp16_pkg`: `FP16_W`=16, state enum `sched_state_t` {RUN, DRAIN, HALT}, and fp16 constants `FP16_ONE`=16'h3C00 and `FP16_ZERO`=16'h0000.
- One sub-module: `rr_pick`.
  - Parameter N.
  - Inputs `valid[N]` and `ptr`.
  - Outputs one-hot `grant[N]` and binary `idx`.
  - Purely combinational.
- The tag pipe and `inflight` counter stay inline.

## Test plan
- Single lane: lane 0 sends a=16'h3E00 (1.5), b=16'h4A00 (12.0), ADD_LAT=2 → `rsp_valid`=4'b0001, `rsp_x`=16'h4AC0 (13.5), exactly 3 cycles after transfer; `inflight` goes 0→1→0.
- Round-robin fairness: all four lanes valid continuously with 16'h3C00+16'h3C00 → grants in order 0,1,2,3,0 on consecutive cycles; every response is 16'h4000 with strobes in the same order.
- Wrap and skip: `ptr`=3, only lanes 1 and 3 valid → grant 3, then 1, then 3.
- Drain: assert `drain_req` while 3 operations are in flight → `req_ready` drops the next cycle; 3 responses emerge; `drain_done`=1 one cycle after the last one; deassert → RUN and grants resume.
- Simultaneous events: a transfer and a response in the same cycle → `inflight` unchanged; `drain_req` rising on a transfer cycle → that operation completes before HALT.
- Reset mid-flight: drive `rst` low with 2 operations in flight → all outputs reach their reset values immediately; no `rsp_valid` after `rst` returns high.
